// File: rtl/seq_multiplier_ext.sv
// -----------------------------------------------------------------------------
// seq_multiplier_ext
//
// Iterative shift-add multiplier for the execute stage. It covers the RV32M
// multiply group (MUL, MULH, MULHSU, MULHU). Each WORK cycle retires
// RADIX_BITS multiplier bits, so a multiply takes N = DATA_W/RADIX_BITS
// WORK cycles.
//
// Signed operands are reduced to magnitudes when the operation is accepted.
// The unsigned magnitude product is built in a 2W-bit accumulator and is
// negated when the signs differ. That negation happens on the final WORK
// edge, so it adds no cycle. The magnitude of the most-negative operand is
// 2^(W-1), which fits exactly in W unsigned bits.
//
// Parameters:
//   DATA_W     operand/result width (>= 4, multiple of RADIX_BITS)
//   RADIX_BITS multiplier bits consumed per WORK cycle (1, 2 or 4)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   flush   synchronous abort, highest priority after reset
//   op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    multiplicand (rs1), multiplier (rs2)
//   result  selected half of the 2W-bit product, held until next completion
//   done    one-cycle pulse when result updates
//   busy    high while in WORK
//
// Handshake: start is accepted on an edge where the FSM is IDLE, start=1 and
// flush=0. op/a/b are captured on that edge. busy is high for exactly the N
// WORK cycles that follow. On the N-th WORK edge, busy falls, result is
// written, and done is high for the following cycle only. A start raised in
// that done cycle is accepted, so back-to-back operations are N+1 cycles
// apart. A start raised while busy is dropped and is not queued. A flush
// abandons the operation: result is left unchanged and no done is produced.
// -----------------------------------------------------------------------------
module seq_multiplier_ext #(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy
);

    localparam int N     = DATA_W / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * DATA_W;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t state, state_next;

    logic              load;    // accept a new operation this edge
    logic              step;    // perform one WORK iteration this edge
    logic              finish;  // this edge is the N-th WORK edge

    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;   // final product must be negated
    logic              high_q;  // return upper half

    // Operand sign handling, evaluated on the live inputs at accept time.
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    // Datapath for one WORK iteration.
    logic [RADIX_BITS-1:0] digit;
    logic [PW-1:0]         acc_sum;
    logic [PW-1:0]         prod;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state and control ----------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    load       = 1'b1;
                    state_next = WORK;
                end
            end
            WORK: begin
                // flush outranks the final iteration: no result, no done
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == WORK);

    // ---------------- operand preparation ----------------
    always_comb begin
        a_signed = (op == 2'b01) || (op == 2'b10);
        b_signed = (op == 2'b01);
        a_neg    = a_signed && a[DATA_W-1];
        b_neg    = b_signed && b[DATA_W-1];
        // Unary minus of the most-negative value yields 2^(W-1), which is
        // the correct unsigned magnitude.
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // ---------------- iteration datapath ----------------
    always_comb begin
        digit   = mplier[RADIX_BITS-1:0];
        acc_sum = acc + (mcand * PW'(digit));
        prod    = neg_q ? -acc_sum : acc_sum;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            high_q <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                acc    <= '0;
                mcand  <= PW'(a_mag);
                mplier <= b_mag;
                cnt    <= '0;
                neg_q  <= a_neg ^ b_neg;
                high_q <= (op != 2'b00);
            end else if (step) begin
                acc    <= acc_sum;
                mcand  <= mcand << RADIX_BITS;
                mplier <= mplier >> RADIX_BITS;
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                result <= high_q ? prod[PW-1:DATA_W] : prod[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier_ext.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_ext
//
// Drives three instances of seq_multiplier_ext (RADIX_BITS = 1, 2, 4 with
// DATA_W = 32) one after another. Each instance runs the same directed vector
// table and then the handshake corner cases: start while busy, flush mid-op,
// flush on the final edge, flush together with start in IDLE, and an
// asynchronous reset mid-op. The bench then runs 1000 random operations,
// spread over the three instances, and checks each against a 64-bit model.
// -----------------------------------------------------------------------------
module tb_seq_multiplier_ext;

    logic        clk;
    logic        rst_n;
    logic        start_v  [3];
    logic        flush_v  [3];
    logic [1:0]  op_v     [3];
    logic [31:0] a_v      [3];
    logic [31:0] b_v      [3];
    logic [31:0] result_v [3];
    logic        done_v   [3];
    logic        busy_v   [3];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_multiplier_ext #(
            .DATA_W     (32),
            .RADIX_BITS ((g == 0) ? 1 : (g == 1) ? 2 : 4)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_v[g]),
            .flush  (flush_v[g]),
            .op     (op_v[g]),
            .a      (a_v[g]),
            .b      (b_v[g]),
            .result (result_v[g]),
            .done   (done_v[g]),
            .busy   (busy_v[g])
        );
    end

    function automatic int n_of(input int u);
        return 32 / ((u == 0) ? 1 : (u == 1) ? 2 : 4);
    endfunction

    // 64-bit reference: extend each operand, then multiply modulo 2^64.
    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{a[31] & ((op == 2'b01) || (op == 2'b10))}}, a};
        eb = {{32{b[31] & (op == 2'b01)}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at #1 after a rising edge. Presents a request. After the accept
    // edge it scrambles op/a/b to show they were captured. It then watches the
    // DUT for up to 120 cycles. Optional events happen at a given WORK-cycle
    // index (-1 disables each one): a start pulse while busy, a flush, or an
    // asynchronous reset pulse.
    task automatic run_op(input int u, input logic [1:0] op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input int poke_at, input int flush_at, input int rst_at,
                          output logic [31:0] res, output int lat,
                          output int busy_cyc, output bit got_done);
        op_v[u]    = op_i;
        a_v[u]     = a_i;
        b_v[u]     = b_i;
        start_v[u] = 1'b1;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
        op_v[u]    = ~op_i;
        a_v[u]     = ~a_i;
        b_v[u]     = b_i ^ 32'h5A5A_A5A5;
        lat        = 0;
        busy_cyc   = 0;
        got_done   = 1'b0;
        while (lat < 120) begin
            if (done_v[u]) begin
                got_done = 1'b1;
                break;
            end
            if (busy_v[u]) busy_cyc++;
            start_v[u] = (lat == poke_at);
            flush_v[u] = (lat == flush_at);
            if (lat == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check($sformatf("u%0d async reset result", u), 64'(result_v[u]), 64'h0);
                check($sformatf("u%0d async reset done", u), 64'(done_v[u]), 64'h0);
                check($sformatf("u%0d async reset busy", u), 64'(busy_v[u]), 64'h0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
            lat++;
        end
        res        = result_v[u];
        start_v[u] = 1'b0;
        flush_v[u] = 1'b0;
    endtask

    // ---------------- per-instance directed sequence ----------------
    task automatic run_unit(input int u);
        int          n, fa, ra, lat, bc;
        bit          gd;
        logic [31:0] res;
        n  = n_of(u);
        fa = (n > 12) ? 10 : n - 2;
        ra = (n > 22) ? 20 : n - 2;

        // Vector table. Consecutive entries run back-to-back, each starting
        // in the previous done cycle.
        for (int i = 0; i < 10; i++) begin
            run_op(u, vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, -1, res, lat, bc, gd);
            check($sformatf("u%0d vec%0d result", u, i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("u%0d vec%0d latency", u, i), 64'(lat), 64'(n));
            check($sformatf("u%0d vec%0d busy cycles", u, i), 64'(bc), 64'(n));
        end

        // A start pulse while busy, with different operands, is ignored.
        run_op(u, 2'b00, 32'd3, 32'd5, 3, -1, -1, res, lat, bc, gd);
        check($sformatf("u%0d poke result", u), 64'(res), 64'd15);
        check($sformatf("u%0d poke latency", u), 64'(lat), 64'(n));

        // Flush mid-operation: busy falls at the next edge, no done follows,
        // and result keeps its previous value.
        run_op(u, 2'b00, 32'd7, 32'd9, -1, fa, -1, res, lat, bc, gd);
        check($sformatf("u%0d flush no done", u), 64'(gd), 64'd0);
        check($sformatf("u%0d flush result held", u), 64'(res), 64'd15);
        check($sformatf("u%0d flush busy cycles", u), 64'(bc), 64'(fa + 1));

        // Flush on the final WORK edge takes priority over completion.
        run_op(u, 2'b00, 32'd7, 32'd9, -1, n - 1, -1, res, lat, bc, gd);
        check($sformatf("u%0d final flush no done", u), 64'(gd), 64'd0);
        check($sformatf("u%0d final flush result held", u), 64'(res), 64'd15);
        check($sformatf("u%0d final flush busy cycles", u), 64'(bc), 64'(n));

        // Flush together with start in IDLE blocks the accept.
        op_v[u]    = 2'b00;
        a_v[u]     = 32'd2;
        b_v[u]     = 32'd2;
        start_v[u] = 1'b1;
        flush_v[u] = 1'b1;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
        flush_v[u] = 1'b0;
        check($sformatf("u%0d idle flush blocks start", u), 64'(busy_v[u]), 64'd0);

        // A new operation after the flushes completes normally.
        run_op(u, 2'b00, 32'd7, 32'd9, -1, -1, -1, res, lat, bc, gd);
        check($sformatf("u%0d post-flush result", u), 64'(res), 64'd63);
        check($sformatf("u%0d post-flush latency", u), 64'(lat), 64'(n));

        // An asynchronous reset mid-operation loses the operation.
        run_op(u, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, ra, res, lat, bc, gd);
        check($sformatf("u%0d reset no done", u), 64'(gd), 64'd0);
        check($sformatf("u%0d reset result", u), 64'(res), 64'h0);

        // The unit recovers after the reset.
        run_op(u, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, -1, -1, -1, res, lat, bc, gd);
        check($sformatf("u%0d recovery result", u), 64'(res), 64'hFFFF_FFFF);
        check($sformatf("u%0d recovery latency", u), 64'(lat), 64'(n));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat, bc, u;
        bit          gd;
        logic [31:0] res, ra, rb;
        logic [1:0]  rop;

        vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{2'b00, 32'h0001_2345, 32'h0000_6789, 32'h75CC_A2ED};
        vecs[2] = '{2'b01, 32'h0001_2345, 32'h0000_6789, 32'h0000_0000};
        vecs[3] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
        vecs[8] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
        vecs[9] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

        // Reset phase.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            flush_v[i] = 1'b0;
            op_v[i]    = 2'b00;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d reset result", i), 64'(result_v[i]), 64'h0);
            check($sformatf("u%0d reset done", i), 64'(done_v[i]), 64'h0);
            check($sformatf("u%0d reset busy", i), 64'(busy_v[i]), 64'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) run_unit(i);

        // Random operations against the 64-bit model.
        for (int i = 0; i < 1000; i++) begin
            u   = i % 3;
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom());
            rb  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom());
            run_op(u, rop, ra, rb, -1, -1, -1, res, lat, bc, gd);
            check($sformatf("rand%0d u%0d op%0d a=%h b=%h", i, u, rop, ra, rb),
                  {31'h0, gd, res}, {31'h0, 1'b1, ref_mul(rop, ra, rb)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
